// File: rtl/serial_nbit_adder_if.sv
// Start/done handshake bundle for the bit-serial N-bit adder.
//   start           request, sampled by the adder only while idle
//   a, b            operands, captured on the accepting edge
//   busy            high while operand bits are being processed
//   done            one-cycle pulse marking sum/cout/overflow valid
//   sum             a+b mod 2^N, held until the next accepted start
//   cout            unsigned carry out of bit N-1
//   overflow        signed two's-complement overflow
// master drives the request side; slave is the adder.
interface serial_nbit_adder_if #(
  parameter int unsigned N = 4
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;

  modport master (
    output start, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/serial_nbit_adder.sv
// Bit-serial N-bit two's-complement adder, LSB first, one bit per clock.
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low; abandons any running operation
//   bus    slave side of serial_nbit_adder_if (start/a/b in;
//          busy/done/sum/cout/overflow out, all registered)
// A start seen in IDLE loads the operands; N SHIFT edges later done pulses
// for one cycle, then the FSM returns to IDLE before another start is taken.
module serial_nbit_adder #(
  parameter int unsigned N = 4
) (
  input logic                clk,
  input logic                rst_n,
  serial_nbit_adder_if.slave bus
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_sh_q, a_sh_d;
  logic [N-1:0]  b_sh_q, b_sh_d;
  logic          carry_q, carry_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // One full-adder slice on the current LSBs.
  logic bit_s;
  logic carry_nxt;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    bit_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) |
                (b_sh_q[0] & carry_q);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sh_d  = bus.a;
          b_sh_d  = bus.b;
          carry_d = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // Result bits enter at the MSB so bit 0 lands at sum[0] after N shifts.
        sum_d   = {bit_s, sum_q[N-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          // carry_q here is the carry into the MSB, carry_nxt the carry out.
          cout_d  = carry_nxt;
          ovf_d   = carry_q ^ carry_nxt;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_nbit_adder.sv
// Directed bench for serial_nbit_adder: an N=4 instance carries most vectors,
// an N=8 instance covers the wider signed-overflow case.
module tb_serial_nbit_adder;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_errors;
  int both_high;

  serial_nbit_adder_if #(.N(4)) bus4 ();
  serial_nbit_adder_if #(.N(8)) bus8 ();

  serial_nbit_adder #(.N(4)) u_dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  serial_nbit_adder #(.N(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // busy and done must never be high together on either instance.
  always @(negedge clk) begin
    if ((bus4.busy && bus4.done) || (bus8.busy && bus8.done))
      both_high++;
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full operation on the N=4 instance with latency and pulse-width checks.
  task automatic run_op4(input string tag, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] es,
                         input logic ec, input logic eo);
    int  k;
    bit  got;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = a;
    bus4.b     = b;
    @(negedge clk);
    bus4.start = 1'b0;
    check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
    k   = 0;
    got = 1'b0;
    while (!got && k < 8) begin
      @(negedge clk);
      k++;
      if (bus4.done) got = 1'b1;
    end
    check({tag, "_lat"}, 32'(k), 32'd4);
    check({tag, "_sum"}, 32'(bus4.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus4.cout), 32'(ec));
    check({tag, "_ovf"}, 32'(bus4.overflow), 32'(eo));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(bus4.done), 32'd0);
  endtask

  initial begin
    int k;
    int pulses;
    int cyc;
    int idx;
    int done_cyc[3];
    logic [3:0] ea[3];
    logic [3:0] eb[3];
    logic [3:0] es[3];
    logic       ec[3];
    logic       eo[3];
    logic [3:0] held;

    n_checks   = 0;
    n_errors   = 0;
    both_high  = 0;
    rst_n      = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_sum", 32'(bus4.sum), 32'd0);
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_flags", 32'({bus4.cout, bus4.overflow}), 32'd0);
    check("rst_sum8", 32'(bus8.sum), 32'd0);
    rst_n = 1'b1;

    // Basic add and carry/overflow corners.
    run_op4("v1", 4'b1010, 4'b0011, 4'b1101, 1'b0, 1'b0);
    run_op4("v2", 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b1);
    run_op4("v3", 4'b1101, 4'b1111, 4'b1100, 1'b1, 1'b0);
    run_op4("v4", 4'b1000, 4'b1000, 4'b0000, 1'b1, 1'b1);

    // Round trip: difference + subtrahend recovers the minuend.
    run_op4("rt1", 4'b0111, 4'b0011, 4'b1010, 1'b0, 1'b1);
    run_op4("rt2", 4'b1100, 4'b1000, 4'b0100, 1'b1, 1'b1);

    // Start while busy is ignored.
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'b0101;
    bus4.b     = 4'b0001;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'b1111;
    bus4.b     = 4'b1111;
    @(negedge clk);
    bus4.start = 1'b0;
    pulses = 0;
    held   = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus4.done) begin
        pulses++;
        held = bus4.sum;
      end
    end
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_sum", 32'(held), 32'(4'b0110));

    // Reset part-way through an operation (cnt==2).
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = 4'b0110;
    bus4.b     = 4'b0101;
    @(negedge clk);
    bus4.start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus4.busy), 32'd0);
    check("mid_rst_sum", 32'(bus4.sum), 32'd0);
    check("mid_rst_flags", 32'({bus4.done, bus4.cout, bus4.overflow}), 32'd0);
    #1 rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus4.done) pulses++;
    end
    check("mid_rst_nodone", 32'(pulses), 32'd0);
    run_op4("post_rst", 4'b0011, 4'b0100, 4'b0111, 1'b0, 1'b0);

    // start held high: back-to-back operations every N+2 edges.
    ea = '{4'h2, 4'h6, 4'h9};
    eb = '{4'h3, 4'h7, 4'h9};
    es = '{4'h5, 4'hD, 4'h2};
    ec = '{1'b0, 1'b0, 1'b1};
    eo = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    bus4.start = 1'b1;
    bus4.a     = ea[0];
    bus4.b     = eb[0];
    idx = 0;
    cyc = 0;
    while (idx < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus4.done) begin
        done_cyc[idx] = cyc;
        check($sformatf("hold_sum%0d", idx), 32'(bus4.sum), 32'(es[idx]));
        check($sformatf("hold_flags%0d", idx),
              32'({bus4.cout, bus4.overflow}), 32'({ec[idx], eo[idx]}));
        idx++;
        if (idx < 3) begin
          bus4.a = ea[idx];
          bus4.b = eb[idx];
        end else begin
          bus4.start = 1'b0;
        end
        @(negedge clk);
        cyc++;
        check($sformatf("hold_idle%0d", idx - 1), 32'(bus4.sum),
              32'(es[idx - 1]));
      end
    end
    check("hold_count", 32'(idx), 32'd3);
    if (idx == 3) begin
      check("hold_gap01", 32'(done_cyc[1] - done_cyc[0]), 32'd6);
      check("hold_gap12", 32'(done_cyc[2] - done_cyc[1]), 32'd6);
    end

    // N=8: 0x7F + 0x01 overflows into the sign bit.
    @(negedge clk);
    bus8.start = 1'b1;
    bus8.a     = 8'h7F;
    bus8.b     = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    k = 0;
    while (!bus8.done && k < 12) begin
      @(negedge clk);
      k++;
    end
    check("w8_lat", 32'(k), 32'd8);
    check("w8_sum", 32'(bus8.sum), 32'h80);
    check("w8_flags", 32'({bus8.cout, bus8.overflow}), 32'b01);

    check("busy_done_excl", 32'(both_high), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
